// File: rtl/motor_pwm_driver.sv
// motor_pwm_driver: turns line-follower drive commands into left/right motor
// PWM plus a shared direction bit. Commands are synchronised, duty ramps up
// softly, the inner wheel is capped while turning, and any direction change
// passes through a dead-time brake with both PWMs held low.
module motor_pwm_driver #(
    parameter int PWM_WIDTH = 8,
    parameter int MAX_DUTY  = 255,
    parameter int TURN_DUTY = 128,
    parameter int RAMP_STEP = 8,
    parameter int RAMP_DIV  = 16,
    parameter int DEADTIME  = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       cmd_fwd,
    input  logic       cmd_rev,
    input  logic       cmd_left,
    input  logic       cmd_right,
    output logic       pwm_left,
    output logic       pwm_right,
    output logic       dir_fwd,
    output logic [1:0] state
);

    localparam int DW1 = PWM_WIDTH + 1;
    localparam int RW  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int TW  = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;

    localparam logic [PWM_WIDTH-1:0] MAX_D  = PWM_WIDTH'(MAX_DUTY);
    localparam logic [PWM_WIDTH-1:0] TURN_D = PWM_WIDTH'(TURN_DUTY);
    localparam logic [RW-1:0]        RAMP_LAST = RW'(RAMP_DIV - 1);
    localparam logic [TW-1:0]        DEAD_LAST = TW'(DEADTIME - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUN_FWD = 2'b01,
        RUN_REV = 2'b10,
        BRAKE   = 2'b11
    } state_t;

    state_t               st;
    logic [4:0]           meta, sync;
    logic [PWM_WIDTH-1:0] duty, pwm_cnt, wheel_l, wheel_r, ramp_next;
    logic [DW1-1:0]       duty_sum;
    logic [RW-1:0]        ramp_cnt;
    logic [TW-1:0]        dead_cnt;
    logic                 en_s, fwd_s, rev_s, left_s, right_s;
    logic                 req_fwd, req_rev, running;

    // Two-flop synchronisers on every asynchronous command input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= {en, cmd_fwd, cmd_rev, cmd_left, cmd_right};
            sync <= meta;
        end
    end

    assign {en_s, fwd_s, rev_s, left_s, right_s} = sync;

    // Conflicting requests or a dropped enable both decode to "no request".
    assign req_fwd = fwd_s & ~rev_s & en_s;
    assign req_rev = rev_s & ~fwd_s & en_s;
    assign running = (st == RUN_FWD) || (st == RUN_REV);

    // Saturating ramp step, one bit wider so it can never wrap.
    assign duty_sum  = {1'b0, duty} + DW1'(RAMP_STEP);
    assign ramp_next = (duty_sum > {1'b0, MAX_D}) ? MAX_D : duty_sum[PWM_WIDTH-1:0];

    // Per-wheel duty: inner wheel capped while turning, zero outside RUN.
    always_comb begin
        wheel_l = '0;
        wheel_r = '0;
        if (running) begin
            wheel_l = (left_s  && (duty > TURN_D)) ? TURN_D : duty;
            wheel_r = (right_s && (duty > TURN_D)) ? TURN_D : duty;
        end
    end

    // Drive FSM with soft-start ramp and dead-time brake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= IDLE;
            duty     <= '0;
            ramp_cnt <= '0;
            dead_cnt <= '0;
            dir_fwd  <= 1'b0;
        end else begin
            case (st)
                IDLE: begin
                    duty     <= '0;
                    ramp_cnt <= '0;
                    dead_cnt <= '0;
                    if (req_fwd) begin
                        st      <= RUN_FWD;
                        dir_fwd <= 1'b1;
                    end else if (req_rev) begin
                        st      <= RUN_REV;
                        dir_fwd <= 1'b0;
                    end
                end
                RUN_FWD, RUN_REV: begin
                    if ((st == RUN_FWD) ? req_fwd : req_rev) begin
                        if (ramp_cnt == RAMP_LAST) begin
                            ramp_cnt <= '0;
                            duty     <= ramp_next;
                        end else begin
                            ramp_cnt <= ramp_cnt + 1'b1;
                        end
                    end else begin
                        // Any change of request goes through the brake first.
                        st       <= BRAKE;
                        duty     <= '0;
                        ramp_cnt <= '0;
                        dead_cnt <= '0;
                    end
                end
                default: begin
                    duty <= '0;
                    if (dead_cnt == DEAD_LAST) begin
                        st       <= IDLE;
                        dead_cnt <= '0;
                    end else begin
                        dead_cnt <= dead_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Free-running PWM counter and registered compare outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt   <= '0;
            pwm_left  <= 1'b0;
            pwm_right <= 1'b0;
        end else begin
            pwm_cnt   <= pwm_cnt + 1'b1;
            pwm_left  <= (pwm_cnt < wheel_l);
            pwm_right <= (pwm_cnt < wheel_r);
        end
    end

    assign state = st;

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Directed bench for motor_pwm_driver: latency, ramp saturation, reversal
// dead-time, turn capping, conflict/enable handling, glitch braking, async reset.
module tb_motor_pwm_driver;

    logic       clk = 1'b0;
    logic       rst_n, en, cmd_fwd, cmd_rev, cmd_left, cmd_right;
    logic       pwm_left, pwm_right, dir_fwd;
    logic [1:0] state;

    int tests = 0;
    int fails = 0;

    motor_pwm_driver dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .cmd_fwd(cmd_fwd), .cmd_rev(cmd_rev),
        .cmd_left(cmd_left), .cmd_right(cmd_right),
        .pwm_left(pwm_left), .pwm_right(pwm_right),
        .dir_fwd(dir_fwd), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait (bounded) until state equals target; reports as a comparison.
    task automatic wait_state(input string tag, input logic [1:0] target, input int budget);
        int n;
        n = 0;
        while (state !== target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, int'(state), int'(target));
    endtask

    // High clocks of each PWM over one full 256-clock period.
    task automatic count_pwm(output int l, output int r);
        l = 0;
        r = 0;
        repeat (256) begin
            @(negedge clk);
            l += int'(pwm_left);
            r += int'(pwm_right);
        end
    endtask

    // Called on the first sample showing BRAKE: length of brake and PWM
    // activity after the first (pipeline-lagged) brake sample.
    task automatic measure_brake(output int len, output int hi);
        len = 1;
        hi  = 0;
        while (len < 100) begin
            @(negedge clk);
            hi += int'(pwm_left) + int'(pwm_right);
            if (state !== 2'b11) break;
            len++;
        end
    endtask

    // Low-duty window at RUN entry: entry sample plus 16 clocks at duty 0.
    task automatic count_start(output int hi);
        hi = int'(pwm_left) + int'(pwm_right);
        repeat (16) begin
            @(negedge clk);
            hi += int'(pwm_left) + int'(pwm_right);
        end
    endtask

    initial begin
        int l, r, len, hi;
        rst_n = 1'b0; en = 1'b0; cmd_fwd = 1'b0; cmd_rev = 1'b0;
        cmd_left = 1'b0; cmd_right = 1'b0;
        tick(3);
        chk("reset_state", int'(state), 0);
        chk("reset_pwm", int'(pwm_left) + int'(pwm_right), 0);
        chk("reset_dir", int'(dir_fwd), 0);
        rst_n = 1'b1;
        tick(5);
        chk("idle_no_req", int'(state), 0);

        // Forward start: state changes on the third clock
        en = 1'b1; cmd_fwd = 1'b1;
        tick(2);
        chk("lat_2clk", int'(state), 0);
        tick(1);
        chk("lat_3clk", int'(state), 1);
        chk("dir_fwd_set", int'(dir_fwd), 1);
        count_start(hi);
        chk("ramp_start_low", hi, 0);
        tick(600);
        count_pwm(l, r);
        chk("full_left", l, 255);
        chk("full_right", r, 255);

        // Reversal through dead-time
        cmd_fwd = 1'b0; cmd_rev = 1'b1;
        tick(2);
        chk("rev_lat2", int'(state), 1);
        tick(1);
        chk("rev_brake", int'(state), 3);
        chk("brake_dir_hold", int'(dir_fwd), 1);
        measure_brake(len, hi);
        chk("rev_brake_len", len, 32);
        chk("rev_brake_pwm", hi, 0);
        chk("rev_idle", int'(state), 0);
        tick(1);
        chk("rev_run", int'(state), 2);
        chk("rev_dir", int'(dir_fwd), 0);
        count_start(hi);
        chk("rev_ramp_restart", hi, 0);
        tick(600);

        // Turn capping
        cmd_left = 1'b1;
        tick(4);
        count_pwm(l, r);
        chk("turnl_left", l, 128);
        chk("turnl_right", r, 255);
        cmd_right = 1'b1;
        tick(4);
        count_pwm(l, r);
        chk("turnb_left", l, 128);
        chk("turnb_right", r, 128);
        cmd_left = 1'b0; cmd_right = 1'b0;

        // Back to RUN_FWD, then conflicting request
        cmd_rev = 1'b0; cmd_fwd = 1'b1;
        wait_state("to_brake_a", 2'b11, 10);
        wait_state("to_fwd_a", 2'b01, 60);
        cmd_rev = 1'b1;
        wait_state("conf_brake", 2'b11, 10);
        wait_state("conf_idle", 2'b00, 40);
        tick(50);
        chk("conf_stays_idle", int'(state), 0);
        cmd_rev = 1'b0;
        wait_state("conf_release_fwd", 2'b01, 10);

        // Enable drop
        en = 1'b0;
        wait_state("en_brake", 2'b11, 10);
        wait_state("en_idle", 2'b00, 40);
        tick(50);
        chk("en_stays_idle", int'(state), 0);
        en = 1'b1;
        wait_state("en_fwd", 2'b01, 10);
        tick(100);

        // Single-clock reverse glitch still brakes
        cmd_rev = 1'b1;
        tick(1);
        cmd_rev = 1'b0;
        tick(2);
        chk("glitch_brake", int'(state), 3);
        measure_brake(len, hi);
        chk("glitch_brake_len", len, 32);
        chk("glitch_brake_pwm", hi, 0);
        chk("glitch_idle", int'(state), 0);
        tick(1);
        chk("glitch_refwd", int'(state), 1);
        count_start(hi);
        chk("glitch_ramp_restart", hi, 0);
        tick(600);
        count_pwm(l, r);
        chk("glitch_full", l + r, 510);

        // Asynchronous reset mid-run, checked before any clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_state", int'(state), 0);
        chk("async_rst_pwm", int'(pwm_left) + int'(pwm_right), 0);
        chk("async_rst_dir", int'(dir_fwd), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
